pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clk` in 1, rising-edge clock; `reset` in 1, asynchronous, active-high.
REQ-002 `id_valid` in 1: the ID stage holds a real instruction.
REQ-003 `id_rs`, `id_rt` in 5 each: source register fields of the ID instruction.
REQ-004 `id_uses_rs`, `id_uses_rt` in 1 each: the ID instruction reads that field.
REQ-005 `id_regwrite` in 1, `id_wreg` in 5: the ID instruction writes register `id_wreg`.
REQ-006 `id_is_lw`, `id_is_beq`, `id_is_j` in 1 each: instruction class decoded in ID.
REQ-007 `id_br_eq` in 1: the ID-stage register comparator reports equal operands.
REQ-008 `pc_write` out 1: PC update enable.
REQ-009 `ifid_write` out 1: IF/ID register enable.
REQ-010 `control_write` out 1: 0 forces the control unit to emit a bubble.
REQ-011 `if_flush` out 1: squash the instruction currently in IF.
REQ-012 `stall_cnt` out 16: saturating count of stall cycles.
REQ-013 `flush_cnt` out 16: saturating count of flush cycles.

Function
REQ-014 The block SHALL keep a shadow EX record `{ex_lw, ex_regwrite, ex_wreg}` and a shadow MEM record `{mem_lw, mem_regwrite, mem_wreg}`, each updated on every rising `clk`.
REQ-015 Each edge, the MEM record SHALL load the EX record.
REQ-016 Each edge, the EX record SHALL load `{id_is_lw, id_regwrite, id_wreg}` when `id_valid & ~stall`, and all-zero otherwise (bubble).
REQ-017 `match(w)` SHALL be `w != 0 & ((id_uses_rs & id_rs == w) | (id_uses_rt & id_rt == w))`; register 0 never creates a hazard.
REQ-018 `load_use` SHALL be `ex_lw & match(ex_wreg)`.
REQ-019 `br_dep` SHALL be `id_is_beq & ((ex_regwrite & match(ex_wreg)) | (mem_lw & match(mem_wreg)))`.
REQ-020 `stall` SHALL be `id_valid & (load_use | br_dep)`, computed combinationally from current inputs and shadow state.
REQ-021 While `stall` = 1: `pc_write` = 0, `ifid_write` = 0, `control_write` = 0, `if_flush` = 0.
REQ-022 While `stall` = 0: `pc_write` = 1, `ifid_write` = 1, `control_write` = 1.
REQ-023 `if_flush` SHALL be `id_valid & ~stall & (id_is_j | (id_is_beq & id_br_eq))`; it is a one-cycle pulse per jump or taken branch.
REQ-024 A stall SHALL take priority over a flush in the same cycle; the flush is asserted only on the first non-stalled cycle.
REQ-025 Stall latency SHALL be:
  - lw then dependent non-branch: 1 cycle;
  - ALU result then dependent beq: 1 cycle;
  - lw then dependent beq: 2 cycles, consecutive, through EX then MEM.
REQ-026 A non-dependent instruction SHALL see zero stall cycles; a lw to register 0 SHALL never stall.
REQ-027 `stall_cnt` SHALL increment on each edge where `stall` = 1 and hold at 16'hFFFF.
REQ-028 `flush_cnt` SHALL increment on each edge where `if_flush` = 1 and hold at 16'hFFFF.
REQ-029 With `id_valid` = 0, the block SHALL assert no stall and no flush, and SHALL shift a bubble into EX.

Reset
REQ-030 While `reset` = 1, independent of `clk`, the block SHALL clear both shadow records and both counters.
REQ-031 With shadow records cleared, outputs follow REQ-022 and REQ-023: `pc_write` = `ifid_write` = `control_write` = 1 and `if_flush` = 0, unless the current ID inputs request a flush.
REQ-032 Reset asserted during a 2-cycle stall SHALL abort the stall immediately; the first cycle after release SHALL not stall.

Verification
REQ-033 lw $8 (wreg=8) in ID, then add reading rs=8 → exactly 1 cycle with `pc_write` = `ifid_write` = `control_write` = 0; `stall_cnt` = 1.
REQ-034 lw $9, then beq rs=9 rt=3 with `id_br_eq` = 1 → 2 consecutive stall cycles, then `if_flush` = 1 for one cycle; `stall_cnt` = 2, `flush_cnt` = 1.
REQ-035 add wreg=5, then beq rs=5 → 1 stall cycle; add wreg=0, then beq rs=0 → 0 stall cycles.
REQ-036 j in ID with no hazard → `if_flush` = 1 for 1 cycle, no stall; beq with `id_br_eq` = 0 → no flush.
REQ-037 Assert `reset` asynchronously mid-way through the lw→beq stall → outputs return to 1/1/1/0 before the next edge, and both counters read 0.
REQ-038 Force 65,536 consecutive load-use stalls → `stall_cnt` saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use and branch-operand hazard control for a 5-stage pipeline with ID-stage branch resolution.
// Shadows the EX/MEM destination info so stall/flush can be decided from ID alone.

module hazard_match (
   input  logic [4:0] wreg,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       uses_rs,
   input  logic       uses_rt,
   output logic       hit
);
   // $0 is hardwired, so a write to it can never be a true dependency
   assign hit = (wreg != 5'd0) &
                ((uses_rs & (rs == wreg)) | (uses_rt & (rt == wreg)));
endmodule

module pipeline_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_regwrite,
   input  logic [4:0]       id_wreg,
   input  logic             id_is_lw,
   input  logic             id_is_beq,
   input  logic             id_is_j,
   input  logic             id_br_eq,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             control_write,
   output logic             if_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int STAGES = 2;  // 1 = EX, 2 = MEM

   typedef struct packed {
      logic       lw;
      logic       regwrite;
      logic [4:0] wreg;
   } shadow_t;

   shadow_t           id_rec;
   shadow_t           shd_pipe [STAGES:1];
   logic [STAGES:1]   hit;
   logic              load_use;
   logic              br_dep;
   logic              stall;
   logic              flush;

   assign id_rec = '{lw: id_is_lw, regwrite: id_regwrite, wreg: id_wreg};

   for (genvar s = 1; s <= STAGES; s++) begin : g_match
      hazard_match u_match (
         .wreg    (shd_pipe[s].wreg),
         .rs      (id_rs),
         .rt      (id_rt),
         .uses_rs (id_uses_rs),
         .uses_rt (id_uses_rt),
         .hit     (hit[s])
      );
   end

   // beq compares in ID, so it must also wait for an ALU result in EX or a load still in MEM
   assign load_use = shd_pipe[1].lw & hit[1];
   assign br_dep   = id_is_beq & ((shd_pipe[1].regwrite & hit[1]) |
                                  (shd_pipe[2].lw & hit[2]));
   assign stall    = id_valid & (load_use | br_dep);
   assign flush    = id_valid & ~stall & (id_is_j | (id_is_beq & id_br_eq));

   always_comb begin
      pc_write      = ~stall;
      ifid_write    = ~stall;
      control_write = ~stall;
      if_flush      = flush;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 1; s <= STAGES; s++) shd_pipe[s] <= '0;
      end else begin
         shd_pipe[1] <= (id_valid & ~stall) ? id_rec : '0;
         for (int s = 2; s <= STAGES; s++) shd_pipe[s] <= shd_pipe[s-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against an issue-history reference model.
// A narrow-counter twin shares the stimulus so saturation is reached in a short run.

module tb_pipeline_hazard_ctrl;
   logic clk = 1'b0, reset = 1'b1;
   logic id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_regwrite = 0;
   logic id_is_lw = 0, id_is_beq = 0, id_is_j = 0, id_br_eq = 0;
   logic [4:0] id_rs = 0, id_rt = 0, id_wreg = 0;
   logic pc_write, ifid_write, control_write, if_flush;
   logic [15:0] stall_cnt, flush_cnt;
   logic s_pc_write, s_ifid_write, s_control_write, s_if_flush;
   logic [7:0] s_stall_cnt, s_flush_cnt;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
      .id_wreg(id_wreg), .id_is_lw(id_is_lw), .id_is_beq(id_is_beq), .id_is_j(id_is_j),
      .id_br_eq(id_br_eq), .pc_write(pc_write), .ifid_write(ifid_write),
      .control_write(control_write), .if_flush(if_flush),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   pipeline_hazard_ctrl #(.CNT_W(8)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
      .id_wreg(id_wreg), .id_is_lw(id_is_lw), .id_is_beq(id_is_beq), .id_is_j(id_is_j),
      .id_br_eq(id_br_eq), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
      .control_write(s_control_write), .if_flush(s_if_flush),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

   // model: what issued one and two cycles ago, plus raw event counts
   bit       h1_lw, h1_rw, h2_lw, h2_rw;
   bit [4:0] h1_w, h2_w;
   int       scnt, fcnt, obs_stl, obs_fl;
   bit       exp_stall, exp_flush;
   int       total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit dep(input bit [4:0] w);
      return (w != 0) && ((id_uses_rs && id_rs == w) || (id_uses_rt && id_rt == w));
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_clear();
      {h1_lw, h1_rw, h1_w, h2_lw, h2_rw, h2_w} = '0;
      scnt = 0; fcnt = 0; obs_stl = 0; obs_fl = 0;
   endtask

   task automatic model_eval();
      exp_stall = id_valid && ((h1_lw && dep(h1_w)) ||
                  (id_is_beq && ((h1_rw && dep(h1_w)) || (h2_lw && dep(h2_w)))));
      exp_flush = id_valid && !exp_stall && (id_is_j || (id_is_beq && id_br_eq));
   endtask

   task automatic check_outs();
      chk("pc_write", pc_write, !exp_stall);
      chk("ifid_write", ifid_write, !exp_stall);
      chk("control_write", control_write, !exp_stall);
      chk("if_flush", if_flush, exp_flush);
      chk("stall_cnt", stall_cnt, sat(scnt, 16'hFFFF));
      chk("flush_cnt", flush_cnt, sat(fcnt, 16'hFFFF));
      chk("sat_stall_cnt", s_stall_cnt, sat(scnt, 255));
      chk("sat_flush_cnt", s_flush_cnt, sat(fcnt, 255));
      chk("sat_pc_write", s_pc_write, !exp_stall);
   endtask

   task automatic cyc();
      @(negedge clk);
      model_eval();
      check_outs();
      obs_stl += (pc_write == 1'b0) ? 1 : 0;
      obs_fl  += (if_flush == 1'b1) ? 1 : 0;
      @(posedge clk);
      if (!reset) begin
         h2_lw = h1_lw; h2_rw = h1_rw; h2_w = h1_w;
         if (id_valid && !exp_stall) begin
            h1_lw = id_is_lw; h1_rw = id_regwrite; h1_w = id_wreg;
         end else begin
            h1_lw = 0; h1_rw = 0; h1_w = 0;
         end
         scnt += exp_stall ? 1 : 0;
         fcnt += exp_flush ? 1 : 0;
      end
      #1;
   endtask

   task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urs,
                         input bit urt, input bit rw, input bit [4:0] w, input bit lw,
                         input bit beq, input bit j, input bit eq);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_regwrite = rw; id_wreg = w; id_is_lw = lw; id_is_beq = beq; id_is_j = j;
      id_br_eq = eq;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      model_clear();
      @(negedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      model_clear();
      #2;
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      chk("rst_pc_write", pc_write, 1);
      chk("rst_if_flush", if_flush, 0);
      do_reset();

      // lw $8 then add reading $8
      set_id(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0); cyc();
      set_id(1, 8, 2, 1, 1, 1, 10, 0, 0, 0, 0); cyc(); cyc();
      idle(); cyc();
      chk("lw_add_stalls", obs_stl, 1);
      chk("lw_add_cnt", stall_cnt, 1);

      // lw $9 then taken beq $9,$3
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0); cyc();
      set_id(1, 9, 3, 1, 1, 0, 0, 0, 1, 0, 1); cyc(); cyc(); cyc();
      idle(); cyc();
      chk("lw_beq_stalls", obs_stl, 2);
      chk("lw_beq_flushes", obs_fl, 1);
      chk("lw_beq_scnt", stall_cnt, 2);
      chk("lw_beq_fcnt", flush_cnt, 1);

      // ALU result then beq; and the $0 variant
      do_reset();
      set_id(1, 1, 2, 1, 1, 1, 5, 0, 0, 0, 0); cyc();
      set_id(1, 5, 6, 1, 1, 0, 0, 0, 1, 0, 0); cyc(); cyc();
      idle(); cyc();
      chk("alu_beq_stalls", obs_stl, 1);
      do_reset();
      set_id(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0); cyc();
      set_id(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0); cyc();
      set_id(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0); cyc();
      set_id(1, 0, 4, 1, 1, 1, 7, 0, 0, 0, 0); cyc();
      idle(); cyc();
      chk("r0_stalls", obs_stl, 0);

      // jump flushes once; untaken beq does not
      do_reset();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
      set_id(1, 3, 4, 1, 1, 0, 0, 0, 1, 0, 0); cyc();
      idle(); cyc();
      chk("j_flushes", obs_fl, 1);
      chk("j_stalls", obs_stl, 0);

      // async reset in the middle of a lw -> beq double stall
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0); cyc();
      set_id(1, 9, 3, 1, 1, 0, 0, 0, 1, 0, 0); cyc();
      @(negedge clk);
      chk("mid_stall_pre", pc_write, 0);
      #1 reset = 1'b1;
      #1;
      chk("arst_pc_write", pc_write, 1);
      chk("arst_ifid_write", ifid_write, 1);
      chk("arst_control_write", control_write, 1);
      chk("arst_if_flush", if_flush, 0);
      chk("arst_stall_cnt", stall_cnt, 0);
      chk("arst_flush_cnt", flush_cnt, 0);
      model_clear();
      #1 reset = 1'b0;
      @(posedge clk); #1;
      cyc();
      chk("arst_after_stalls", obs_stl, 0);
      idle(); cyc();

      // long lw -> dependent beq burst drives the narrow counters into saturation
      do_reset();
      for (int i = 0; i < 200; i++) begin
         set_id(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0); cyc();
         set_id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0); cyc(); cyc(); cyc();
      end
      idle(); cyc();
      chk("burst_scnt", stall_cnt, 400);
      chk("burst_sat_scnt", s_stall_cnt, 8'hFF);

      // randomized traffic, small register range so hazards are frequent
      for (int i = 0; i < 3000; i++) begin
         if (!exp_stall || !id_valid) begin
            int cls;
            cls = $urandom_range(0, 9);
            set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), cls < 6, 5'($urandom_range(0, 3)),
                   cls < 3, cls == 6 || cls == 7, cls == 8, 1'($urandom));
         end
         cyc();
      end
      idle(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
